// File: rtl/cs_pkg.sv
// Shared definitions for the compressed-sensing sample link (transmitter and receiver).
// Holds the sample width, default frame geometry and the slot-count helper.
package cs_pkg;

    localparam int unsigned SAMPLE_W  = 16;
    localparam int unsigned CS_M      = 40;
    localparam int unsigned CS_N_PINS = 4;

    typedef enum logic {
        StHunt,
        StCollect
    } rx_state_e;

    function automatic int unsigned cs_n_slots(input int unsigned m, input int unsigned pins);
        return (m + pins - 1) / pins;
    endfunction

endpackage

// File: rtl/cs_frame_buffer.sv
// Presented-frame register with valid/ready handshake.
// Arbitrates commits against accepts, flags dropped frames and counts committed frames.
module cs_frame_buffer
    import cs_pkg::*;
#(
    parameter int unsigned FRAME_W = 640
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_commit,
    input  logic [FRAME_W-1:0] i_frame,
    input  logic               i_ready,
    output logic [FRAME_W-1:0] o_data,
    output logic               o_valid,
    output logic               o_overrun,
    output logic [15:0]        o_count
);

    logic [FRAME_W-1:0] r_data;
    logic               r_valid;
    logic               r_overrun;
    logic [15:0]        r_count;
    logic               w_slot_free;

    // A commit may replace the presented frame only if it is empty or leaving this cycle.
    assign w_slot_free = ~r_valid | i_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_count   <= '0;
        end else begin
            r_overrun <= 1'b0;
            if (i_commit) begin
                if (w_slot_free) begin
                    r_data  <= i_frame;
                    r_valid <= 1'b1;
                    r_count <= r_count + 16'd1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
    assign o_count   = r_count;

endmodule

// File: rtl/compressed_demux_receiver.sv
// Receive end of the compressed-sensing mux link: hunts for start-of-frame, assembles
// N_SLOTS beats of N_PINS lanes into an M-sample frame and hands it to the output buffer.
module compressed_demux_receiver
    import cs_pkg::*;
#(
    parameter int unsigned M      = CS_M,
    parameter int unsigned N_PINS = CS_N_PINS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SAMPLE_W*N_PINS-1:0]   mux_in,
    input  logic                         mux_valid,
    input  logic                         mux_sof,
    output logic [SAMPLE_W*M-1:0]        signals_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         frame_err,
    output logic                         overrun,
    output logic [15:0]                  frame_count
);

    localparam int unsigned N_SLOTS    = cs_n_slots(M, N_PINS);
    localparam int unsigned BEAT_W     = SAMPLE_W * N_PINS;
    localparam int unsigned ASM_W      = N_SLOTS * BEAT_W;
    localparam int unsigned FRAME_W    = SAMPLE_W * M;
    localparam int unsigned CNT_W      = $clog2(N_SLOTS + 1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_SLOTS - 1);

    rx_state_e        r_state;
    logic [CNT_W-1:0] r_slot_cnt;
    logic [ASM_W-1:0] r_asm;
    logic             r_frame_err;

    logic             w_sof;
    logic             w_take;
    logic [CNT_W-1:0] w_slot;
    logic [ASM_W-1:0] w_asm_next;
    logic             w_commit;
    logic [FRAME_W-1:0] w_frame;

    always_comb begin
        w_sof      = mux_valid & mux_sof;
        w_take     = w_sof | (mux_valid & (r_state == StCollect));
        // A sof beat always restarts at slot 0, abandoning any partial frame.
        w_slot     = w_sof ? '0 : r_slot_cnt;
        w_asm_next = r_asm;
        w_asm_next[int'(w_slot) * BEAT_W +: BEAT_W] = mux_in;
        w_commit   = w_take & (w_slot == LAST_SLOT);
        // Lanes beyond M in the last slot fall off the top here.
        w_frame    = w_asm_next[FRAME_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StHunt;
            r_slot_cnt  <= '0;
            r_asm       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_sof & (r_state == StCollect);
            if (w_take) begin
                r_asm <= w_asm_next;
                if (w_commit) begin
                    r_state    <= StHunt;
                    r_slot_cnt <= '0;
                end else begin
                    r_state    <= StCollect;
                    r_slot_cnt <= w_slot + CNT_W'(1);
                end
            end
        end
    end

    assign frame_err = r_frame_err;

    cs_frame_buffer #(
        .FRAME_W (FRAME_W)
    ) u_frame_buffer (
        .clk       (clk),
        .reset     (reset),
        .i_commit  (w_commit),
        .i_frame   (w_frame),
        .i_ready   (out_ready),
        .o_data    (signals_out),
        .o_valid   (out_valid),
        .o_overrun (overrun),
        .o_count   (frame_count)
    );

endmodule

// File: tb/tb_compressed_demux_receiver.sv
// Randomized and directed bench for compressed_demux_receiver against a
// queue-based frame model derived from the link's slot-mapping rules.
module tb_compressed_demux_receiver;

    localparam int M  = 40;
    localparam int NP = 4;
    localparam int NS = (M + NP - 1) / NP;
    localparam int BW = 16 * NP;
    localparam int FW = 16 * M;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [BW-1:0] mux_in = '0;
    logic          mux_valid = 1'b0;
    logic          mux_sof = 1'b0;
    logic [FW-1:0] signals_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          frame_err;
    logic          overrun;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    compressed_demux_receiver #(
        .M      (M),
        .N_PINS (NP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mux_in      (mux_in),
        .mux_valid   (mux_valid),
        .mux_sof     (mux_sof),
        .signals_out (signals_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: received beats of the frame in progress, plus presented output.
    logic [BW-1:0] m_part[$];
    logic [FW-1:0] m_out;
    bit            m_valid;
    bit            m_err;
    bit            m_ovr;
    logic [15:0]   m_cnt;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_part.delete();
        m_out   = '0;
        m_valid = 0;
        m_err   = 0;
        m_ovr   = 0;
        m_cnt   = '0;
    endtask

    task automatic model_beat(input bit v, input bit s, input logic [BW-1:0] d, input bit rdy);
        bit            done;
        logic [FW-1:0] f;
        logic [BW-1:0] w;
        done  = 0;
        f     = '0;
        m_err = 0;
        m_ovr = 0;
        if (v) begin
            if (s) begin
                if (m_part.size() > 0) m_err = 1;
                m_part.delete();
                m_part.push_back(d);
            end else if (m_part.size() > 0) begin
                m_part.push_back(d);
            end
            if (m_part.size() == NS) begin
                done = 1;
                for (int i = 0; i < M; i++) begin
                    w = m_part[i / NP];
                    f[i*16 +: 16] = w[(i % NP)*16 +: 16];
                end
                m_part.delete();
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_out   = f;
                m_valid = 1;
                m_cnt   = m_cnt + 16'd1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs();
        chk("out_valid",   FW'(out_valid),   FW'(m_valid));
        chk("signals_out", signals_out,      m_out);
        chk("frame_err",   FW'(frame_err),   FW'(m_err));
        chk("overrun",     FW'(overrun),     FW'(m_ovr));
        chk("frame_count", FW'(frame_count), FW'(m_cnt));
    endtask

    task automatic step(input bit v, input bit s, input logic [BW-1:0] d, input bit rdy);
        @(negedge clk);
        mux_valid = v;
        mux_sof   = s;
        mux_in    = d;
        out_ready = rdy;
        @(posedge clk);
        model_beat(v, s, d, rdy);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        mux_valid = 1'b0;
        mux_sof   = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [BW-1:0] mk_beat(input int base, input int k);
        logic [BW-1:0] b;
        for (int p = 0; p < NP; p++) b[p*16 +: 16] = 16'(base + k*NP + p);
        return b;
    endfunction

    // rmode: 0 ready low, 1 ready high, 2 ready high only on the final slot beat.
    task automatic send_frame(input int base, input int gap, input int nbeats, input int rmode);
        bit rdy;
        for (int k = 0; k < nbeats; k++) begin
            rdy = (rmode == 1) || (rmode == 2 && k == NS - 1);
            step(1, k == 0, mk_beat(base, k), rdy);
            if (k < nbeats - 1)
                for (int g = 0; g < gap; g++) step(0, 0, {$urandom, $urandom}, rmode == 1);
        end
    endtask

    initial begin
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;

        // Clean and gapped frames with ready held high.
        send_frame(0, 0, NS, 1);
        step(0, 0, '0, 1);
        send_frame(0, 3, NS, 1);
        step(0, 0, '0, 1);

        // Early sof after five slots, then a full frame.
        send_frame(500, 0, 5, 1);
        send_frame(100, 0, NS, 1);
        step(0, 0, '0, 1);

        // Overrun: two frames with ready low, then release.
        send_frame(0, 0, NS, 0);
        send_frame(200, 0, NS, 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);

        // Simultaneous accept on B's final beat while A is held.
        send_frame(0, 0, NS, 0);
        send_frame(200, 0, NS, 2);
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);

        // Reset mid-frame, sof-less beats ignored, then a proper frame.
        send_frame(300, 0, 4, 1);
        do_reset();
        for (int k = 0; k < NS; k++) step(1, 0, mk_beat(700, k), 1);
        send_frame(0, 0, NS, 1);

        // Back-to-back frames.
        send_frame(1000, 0, NS, 1);
        send_frame(2000, 0, NS, 1);
        step(0, 0, '0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end else if ($urandom_range(0, 99) < 3) begin
                send_frame($urandom_range(0, 60000), $urandom_range(0, 2), NS,
                           $urandom_range(0, 2));
            end else begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                     {$urandom, $urandom}, $urandom_range(0, 9) < 6);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
